// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, latencies and hazard helper for the pipeline controller.
package pipe_ctrl_pkg;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;
   localparam int unsigned T_W          = 2;
   localparam int unsigned CNT_W        = 4;

   typedef logic [T_W-1:0] tcyc_t;
   typedef logic [4:0]     reg_idx_t;

   // An operand that is never read carries this Tuse, which no Tnew can exceed.
   localparam tcyc_t TUSE_UNUSED = tcyc_t'(3);

   function automatic logic src_hazard(input reg_idx_t src, input tcyc_t tuse,
                                       input reg_idx_t e_a3, input tcyc_t e_tnew,
                                       input reg_idx_t m_a3, input tcyc_t m_tnew);
      return (src != '0) &&
             (((e_a3 == src) && (tuse < e_tnew)) ||
              ((m_a3 == src) && (tuse < m_tnew)));
   endfunction

endpackage

// File: rtl/pipe_ctrl_md_busy_cnt.sv
// MDU busy tracker: down-counter loaded on start, last start wins.
module md_busy_cnt
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic done
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = is_div ? DIV_LD : MULT_LD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);
   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard detection and stage-register control for the five-stage pipeline.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_Tuse_rs,
   input  logic [1:0] D_Tuse_rt,
   input  logic       D_isMD,
   input  logic [4:0] E_A3,
   input  logic [4:0] M_A3,
   input  logic [1:0] E_Tnew,
   input  logic [1:0] M_Tnew,
   input  logic       E_start,
   input  logic       E_isDiv,
   output logic       PC_en,
   output logic       FD_en,
   output logic       DE_en,
   output logic       EM_en,
   output logic       MW_en,
   output logic       DE_reset,
   output logic       EM_reset,
   output logic       MW_reset,
   output logic       E_busy,
   output logic       E_done
);

   logic stall_rs, stall_rt, stall_md, stall;

   md_busy_cnt #(
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_busy_cnt (
      .clk   (clk),
      .reset (reset),
      .start (E_start),
      .is_div(E_isDiv),
      .busy  (E_busy),
      .done  (E_done)
   );

   always_comb begin
      stall_rs = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
      stall_rt = src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
      stall_md = D_isMD && (E_busy || E_start);
      // Stage registers clear themselves during reset, so no stall is raised then.
      stall    = (stall_rs || stall_rt || stall_md) && !reset;
   end

   always_comb begin
      PC_en    = !stall;
      FD_en    = !stall;
      DE_en    = 1'b1;
      EM_en    = 1'b1;
      MW_en    = 1'b1;
      DE_reset = stall;
      EM_reset = 1'b0;
      MW_reset = 1'b0;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, MDU busy timing, async reset, restart.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] D_rs = '0, D_rt = '0, E_A3 = '0, M_A3 = '0;
   logic [1:0] D_Tuse_rs = 2'd3, D_Tuse_rt = 2'd3, E_Tnew = '0, M_Tnew = '0;
   logic       D_isMD = 1'b0, E_start = 1'b0, E_isDiv = 1'b0;
   logic       PC_en, FD_en, DE_en, EM_en, MW_en;
   logic       DE_reset, EM_reset, MW_reset, E_busy, E_done;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   pipe_ctrl #(
      .MULT_LAT(5),
      .DIV_LAT (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .D_rs     (D_rs),
      .D_rt     (D_rt),
      .D_Tuse_rs(D_Tuse_rs),
      .D_Tuse_rt(D_Tuse_rt),
      .D_isMD   (D_isMD),
      .E_A3     (E_A3),
      .M_A3     (M_A3),
      .E_Tnew   (E_Tnew),
      .M_Tnew   (M_Tnew),
      .E_start  (E_start),
      .E_isDiv  (E_isDiv),
      .PC_en    (PC_en),
      .FD_en    (FD_en),
      .DE_en    (DE_en),
      .EM_en    (EM_en),
      .MW_en    (MW_en),
      .DE_reset (DE_reset),
      .EM_reset (EM_reset),
      .MW_reset (MW_reset),
      .E_busy   (E_busy),
      .E_done   (E_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pack all control outputs: {PC,FD,DE,EM,MW enables, DE,EM,MW resets}.
   function automatic logic [31:0] ctl();
      return {24'd0, PC_en, FD_en, DE_en, EM_en, MW_en, DE_reset, EM_reset, MW_reset};
   endfunction

   localparam logic [31:0] CTL_RUN   = 32'b1111_1000;
   localparam logic [31:0] CTL_STALL = 32'b0011_1100;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hazards();
      D_rs = '0; D_rt = '0; E_A3 = '0; M_A3 = '0;
      D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; E_Tnew = '0; M_Tnew = '0;
      D_isMD = 1'b0; E_start = 1'b0; E_isDiv = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with a load-use hazard presented: controls must stay in run mode.
      #1;
      reset = 1'b1;
      E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
      #1;
      check("rst_ctl", ctl(), CTL_RUN);
      check("rst_busy", {30'd0, E_busy, E_done}, 32'd0);
      tick(); tick();
      reset = 1'b0;
      #1;

      check("loaduse_stall", ctl(), CTL_STALL);
      tick();
      E_Tnew = 2'd1; M_A3 = 5'd8; M_Tnew = 2'd1;
      #1;
      check("loaduse_resolved", ctl(), CTL_RUN);

      clear_hazards();
      D_rt = 5'd9; M_A3 = 5'd9; M_Tnew = 2'd2; D_Tuse_rt = 2'd1;
      #1;
      check("rt_m_stall", ctl(), CTL_STALL);
      D_Tuse_rt = 2'd2;
      #1;
      check("rt_tuse_eq_tnew", ctl(), CTL_RUN);
      D_Tuse_rt = 2'd3; E_A3 = 5'd9; E_Tnew = 2'd3;
      #1;
      check("rt_unused", ctl(), CTL_RUN);

      clear_hazards();
      D_rs = 5'd0; E_A3 = 5'd0; E_Tnew = 2'd2; D_Tuse_rs = 2'd0;
      #1;
      check("zero_reg", ctl(), CTL_RUN);

      // Mult: busy t+1..t+5, done only at t+5.
      clear_hazards();
      E_start = 1'b1; E_isDiv = 1'b0;
      #1;
      check("mult_t_busy", {31'd0, E_busy}, 32'd0);
      check("mult_nomd_ctl", ctl(), CTL_RUN);
      tick();
      E_start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         #1;
         check($sformatf("mult_busy_%0d", i), {31'd0, E_busy}, 32'd1);
         check($sformatf("mult_done_%0d", i), {31'd0, E_done}, {31'd0, (i == 5)});
         tick();
      end
      check("mult_end_busy", {30'd0, E_busy, E_done}, 32'd0);

      // Div with a waiting MD instruction: stall t..t+10, free at t+11.
      E_start = 1'b1; E_isDiv = 1'b1; D_isMD = 1'b1;
      #1;
      check("div_t_stall", ctl(), CTL_STALL);
      tick();
      E_start = 1'b0; E_isDiv = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         #1;
         check($sformatf("div_stall_%0d", i), ctl(), CTL_STALL);
         check($sformatf("div_done_%0d", i), {31'd0, E_done}, {31'd0, (i == 10)});
         tick();
      end
      check("div_end_ctl", ctl(), CTL_RUN);
      check("div_end_busy", {31'd0, E_busy}, 32'd0);
      D_isMD = 1'b0;

      // Asynchronous reset in the middle of a divide.
      E_start = 1'b1; E_isDiv = 1'b1;
      tick();
      E_start = 1'b0; E_isDiv = 1'b0;
      tick(); tick(); tick();
      check("rmid_busy_before", {31'd0, E_busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rmid_busy_async", {30'd0, E_busy, E_done}, 32'd0);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rmid_idle_%0d", i), {31'd0, E_busy}, 32'd0);
      end

      // Restart: mult at t, div at t+2, busy through t+12, done only at t+12.
      E_start = 1'b1; E_isDiv = 1'b0;
      tick();
      E_start = 1'b0;
      #1;
      check("rs_t1_busy", {30'd0, E_busy, E_done}, 32'd2);
      tick();
      E_start = 1'b1; E_isDiv = 1'b1;
      #1;
      check("rs_t2_busy", {30'd0, E_busy, E_done}, 32'd2);
      tick();
      E_start = 1'b0; E_isDiv = 1'b0;
      for (int i = 3; i <= 12; i++) begin
         #1;
         check($sformatf("rs_busy_%0d", i), {31'd0, E_busy}, 32'd1);
         check($sformatf("rs_done_%0d", i), {31'd0, E_done}, {31'd0, (i == 12)});
         tick();
      end
      check("rs_end_busy", {30'd0, E_busy, E_done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
